// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver clocked entirely by the system Clock.
// Raw PS2_CLK/PS2_DATA are synchronised, the clock line is glitch filtered,
// 11-bit frames are deframed and checked, E0/F0 prefixes are folded into
// flags, and decoded codes are queued in a first-word-fall-through FIFO.
module ps2_scancode_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         PS2_CLK,
  input  logic                         PS2_DATA,
  input  logic                         iPop,
  output logic                         oValid,
  output logic [7:0]                   oData,
  output logic                         oExtended,
  output logic                         oBreak,
  output logic [$clog2(FIFO_DEPTH):0]  oCount,
  output logic                         oParityError,
  output logic                         oFrameError,
  output logic                         oOverflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity: the eight data bits plus the parity bit must hold an odd number of ones.
  function automatic logic f_odd_parity_ok(input logic [7:0] data, input logic parity);
    return (^data) ^ parity;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers, glitch filter and fall strobe
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   w_clk_sync;
  logic                   w_data_sync;
  logic                   r_clk_filt;
  logic [FILT_W-1:0]      r_filt_cnt;
  logic                   r_fall;
  logic                   r_fall_data;

  assign w_clk_sync  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_sync = r_data_sync[SYNC_STAGES-1];

  // Bring both asynchronous PS/2 lines into the Clock domain (idle level is high).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], PS2_DATA};
    end
  end

  // Accept a new PS2_CLK level only after FILTER_LEN stable cycles; strobe on accepted falls.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_clk_filt  <= 1'b1;
      r_filt_cnt  <= '0;
      r_fall      <= 1'b0;
      r_fall_data <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_clk_sync == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
        r_clk_filt  <= w_clk_sync;
        r_filt_cnt  <= '0;
        r_fall      <= (r_clk_filt == 1'b1);
        r_fall_data <= w_data_sync;
      end else begin
        r_filt_cnt <= r_filt_cnt + FILT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Deframing FSM
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic              r_parity;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_timeout;
  logic              w_accept;
  logic              w_par_err;
  logic              w_stop_err;

  // A frame is abandoned when no accepted fall arrives for TIMEOUT_CYCLES mid-frame.
  assign w_timeout = (r_state != ST_IDLE) && !r_fall &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus frame verdict on the stop-bit fall; parity error outranks stop error.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_par_err    = 1'b0;
    w_stop_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_fall && !r_fall_data) begin
          w_state_next = ST_DATA;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (w_timeout) begin
          w_state_next = ST_IDLE;
        end else if (r_fall && (r_bit_cnt == 3'd7)) begin
          w_state_next = ST_PARITY;
        end else begin
          w_state_next = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_timeout) begin
          w_state_next = ST_IDLE;
        end else if (r_fall) begin
          w_state_next = ST_STOP;
        end else begin
          w_state_next = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (w_timeout) begin
          w_state_next = ST_IDLE;
        end else if (r_fall) begin
          w_state_next = ST_IDLE;
          if (!f_odd_parity_ok(r_shift, r_parity)) begin
            w_par_err = 1'b1;
          end else if (!r_fall_data) begin
            w_stop_err = 1'b1;
          end else begin
            w_accept = 1'b1;
          end
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Shift data bits in LSB first, count them, and capture the parity bit.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_parity  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_fall && !r_fall_data) begin
            r_bit_cnt <= 3'd0;
          end
        end
        ST_DATA: begin
          if (r_fall) begin
            r_shift   <= {r_fall_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          if (r_fall) begin
            r_parity <= r_fall_data;
          end
        end
        default: begin
          r_bit_cnt <= r_bit_cnt;
        end
      endcase
    end
  end

  // Mid-frame watchdog: restarts on every accepted fall and whenever the FSM is idle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_IDLE) || r_fall || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame verdict registers and prefix decode
  // ---------------------------------------------------------------------------
  logic       r_acc_valid;
  logic [7:0] r_acc_byte;
  logic       r_par_err;
  logic       r_frm_err;
  logic       r_ext_flag;
  logic       r_brk_flag;
  logic       w_is_e0;
  logic       w_is_f0;
  logic       w_push;

  // Hold the accepted byte for one cycle and turn errors into single-cycle pulses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_acc_valid <= 1'b0;
      r_acc_byte  <= 8'h00;
      r_par_err   <= 1'b0;
      r_frm_err   <= 1'b0;
    end else begin
      r_acc_valid <= w_accept;
      r_acc_byte  <= w_accept ? r_shift : r_acc_byte;
      r_par_err   <= w_par_err;
      r_frm_err   <= w_stop_err | w_timeout;
    end
  end

  assign w_is_e0 = r_acc_valid && (r_acc_byte == 8'hE0);
  assign w_is_f0 = r_acc_valid && (r_acc_byte == 8'hF0);
  assign w_push  = r_acc_valid && !w_is_e0 && !w_is_f0;

  // Prefix flags: set by E0/F0, consumed by the next pushed code, dropped on any frame error.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
    end else if (w_par_err || w_stop_err || w_timeout) begin
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
    end else if (w_is_e0) begin
      r_ext_flag <= 1'b1;
    end else if (w_is_f0) begin
      r_brk_flag <= 1'b1;
    end else if (w_push) begin
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
    end else begin
      r_ext_flag <= r_ext_flag;
      r_brk_flag <= r_brk_flag;
    end
  end

  // ---------------------------------------------------------------------------
  // Decoded-code FIFO, entries are {ext, brk, code}
  // ---------------------------------------------------------------------------
  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_valid;
  logic             r_overflow;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic [9:0]       w_head;

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = iPop && (r_count != '0);
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage write port.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 10'h000;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {r_ext_flag, r_brk_flag, r_acc_byte};
    end
  end

  // Pointers (wrap naturally at the power-of-two depth), count, valid and sticky overflow.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_push_ok ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
      r_rd_ptr   <= w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
      r_count    <= w_count_next;
      r_valid    <= (w_count_next != '0);
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign oValid       = r_valid;
  assign oData        = w_head[7:0];
  assign oBreak       = w_head[8];
  assign oExtended    = w_head[9];
  assign oCount       = r_count;
  assign oParityError = r_par_err;
  assign oFrameError  = r_frm_err;
  assign oOverflow    = r_overflow;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Self-checking bench for ps2_scancode_receiver: a table of frames with
// hand-derived expectations, hand-written corner sequences, and random frames
// compared against a frame-level queue model of the keyboard protocol.
module tb_ps2_scancode_receiver;

  localparam int DEPTH = 8;
  localparam int TO    = 200;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic       iPop = 1'b0;
  logic       oValid;
  logic [7:0] oData;
  logic       oExtended;
  logic       oBreak;
  logic [3:0] oCount;
  logic       oParityError;
  logic       oFrameError;
  logic       oOverflow;

  ps2_scancode_receiver #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA), .iPop(iPop),
    .oValid(oValid), .oData(oData), .oExtended(oExtended), .oBreak(oBreak),
    .oCount(oCount), .oParityError(oParityError), .oFrameError(oFrameError),
    .oOverflow(oOverflow)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int perr_seen = 0;
  int ferr_seen = 0;

  // Count error-pulse cycles; a stuck pulse inflates the count.
  always @(negedge Clock) begin
    if (oParityError) perr_seen++;
    if (oFrameError)  ferr_seen++;
  end

  // ---------------- reference model (frame level) ----------------
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } entry_t;

  entry_t m_q[$];
  bit     m_ext, m_brk, m_ovf;
  int     m_perr = 0, m_ferr = 0;

  function automatic void model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    entry_t e;
    if (!par_ok) begin
      m_perr++; m_ext = 0; m_brk = 0;
    end else if (!stop_ok) begin
      m_ferr++; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      e.ext = m_ext; e.brk = m_brk; e.code = b;
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic void model_reset();
    m_q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " valid"}, 32'(oValid), 32'(m_q.size() != 0));
    check({tag, " count"}, 32'(oCount), 32'(m_q.size()));
    if (m_q.size() != 0) begin
      check({tag, " data"}, 32'(oData), 32'(m_q[0].code));
      check({tag, " ext"},  32'(oExtended), 32'(m_q[0].ext));
      check({tag, " brk"},  32'(oBreak), 32'(m_q[0].brk));
    end
    check({tag, " ovf"},  32'(oOverflow), 32'(m_ovf));
    check({tag, " perr"}, 32'(perr_seen), 32'(m_perr));
    check({tag, " ferr"}, 32'(ferr_seen), 32'(m_ferr));
  endtask

  // ---------------- stimulus helpers ----------------
  // One PS/2 bit: data set while clock high, 10-cycle low phase, 5-cycle high tail.
  task automatic ps2_bit(input logic b, input bit glitch, input bit pop_here);
    @(negedge Clock) PS2_DATA = b;
    repeat (2) @(negedge Clock);
    if (glitch) begin
      PS2_CLK = 1'b0;
      @(negedge Clock) PS2_CLK = 1'b1;
    end else begin
      @(negedge Clock);
    end
    repeat (2) @(negedge Clock);
    PS2_CLK = 1'b0;
    if (pop_here) begin
      // Aim iPop at the cycle in which the decoded code is pushed.
      repeat (7) @(negedge Clock);
      iPop = 1'b1;
      @(negedge Clock) iPop = 1'b0;
      repeat (2) @(negedge Clock);
    end else begin
      repeat (10) @(negedge Clock);
    end
    PS2_CLK = 1'b1;
    repeat (5) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                            input int glitch_idx, input bit pop_at_stop);
    logic [10:0] bits;
    logic        p;
    p    = par_ok ? ~(^b) : (^b);
    bits = {stop_ok ? 1'b1 : 1'b0, p, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_bit(bits[i], glitch_idx == i, pop_at_stop && (i == 10));
    end
    repeat (5) @(negedge Clock);
  endtask

  task automatic do_pop();
    @(negedge Clock) iPop = 1'b1;
    @(negedge Clock) iPop = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
    repeat (2) @(negedge Clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"},  32'(oValid), 32'd0);
    check({tag, " count"},  32'(oCount), 32'd0);
    check({tag, " data"},   32'(oData), 32'd0);
    check({tag, " extbrk"}, 32'({oExtended, oBreak}), 32'd0);
    check({tag, " errs"},   32'({oParityError, oFrameError}), 32'd0);
    check({tag, " ovf"},    32'(oOverflow), 32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] code;
    bit         par_ok;
    bit         stop_ok;
    bit         pop;
    int         exp_count;
    logic [7:0] exp_data;
    bit         exp_ext;
    bit         exp_brk;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [7:0] pre;
    logic [7:0] code;
    //           code  par stp pop cnt data  e  b  pe fe
    vt[0]  = '{8'h1D, 1, 1, 1, 1, 8'h1D, 0, 0, 0, 0};
    vt[1]  = '{8'hF0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[2]  = '{8'h1D, 1, 1, 1, 1, 8'h1D, 0, 1, 0, 0};
    vt[3]  = '{8'hE0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[4]  = '{8'hF0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[5]  = '{8'h75, 1, 1, 1, 1, 8'h75, 1, 1, 0, 0};
    vt[6]  = '{8'h1C, 1, 1, 1, 1, 8'h1C, 0, 0, 0, 0};
    vt[7]  = '{8'hF0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[8]  = '{8'h1C, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0};
    vt[9]  = '{8'h1C, 1, 1, 1, 1, 8'h1C, 0, 0, 1, 0};
    vt[10] = '{8'hF0, 1, 1, 0, 0, 8'h00, 0, 0, 1, 0};
    vt[11] = '{8'h1C, 1, 0, 0, 0, 8'h00, 0, 0, 1, 1};
    vt[12] = '{8'h22, 0, 0, 0, 0, 8'h00, 0, 0, 2, 1};
    vt[13] = '{8'h1C, 1, 1, 1, 1, 8'h1C, 0, 0, 2, 1};

    model_reset();
    repeat (3) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b0;
    repeat (5) @(negedge Clock);

    for (int i = 0; i < 14; i++) begin
      send_frame(vt[i].code, vt[i].par_ok, vt[i].stop_ok, -1, 1'b0);
      model_frame(vt[i].code, vt[i].par_ok, vt[i].stop_ok);
      check($sformatf("vec%0d count", i), 32'(oCount), 32'(vt[i].exp_count));
      check($sformatf("vec%0d valid", i), 32'(oValid), 32'(vt[i].exp_count != 0));
      if (vt[i].exp_count != 0) begin
        check($sformatf("vec%0d data", i), 32'(oData), 32'(vt[i].exp_data));
        check($sformatf("vec%0d ext", i),  32'(oExtended), 32'(vt[i].exp_ext));
        check($sformatf("vec%0d brk", i),  32'(oBreak), 32'(vt[i].exp_brk));
      end
      check($sformatf("vec%0d perr", i), 32'(perr_seen), 32'(vt[i].exp_perr));
      check($sformatf("vec%0d ferr", i), 32'(ferr_seen), 32'(vt[i].exp_ferr));
      if (vt[i].pop) begin
        do_pop();
        check($sformatf("vec%0d popvalid", i), 32'(oValid), 32'd0);
        check($sformatf("vec%0d popcount", i), 32'(oCount), 32'd0);
      end
    end

    // Timeout: pending F0, then 5 bits of a frame and a silent clock.
    send_frame(8'hF0, 1, 1, -1, 1'b0);
    model_frame(8'hF0, 1, 1);
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1, 1'b0, 1'b0);
    repeat (TO + 60) @(negedge Clock);
    m_ferr++; m_ext = 0; m_brk = 0;
    check_model("timeout");
    send_frame(8'h23, 1, 1, -1, 1'b0);
    model_frame(8'h23, 1, 1);
    check_model("after_timeout");
    do_pop();

    // Clock glitches: one while idle before the start bit, one mid-frame.
    send_frame(8'h34, 1, 1, 0, 1'b0);
    model_frame(8'h34, 1, 1);
    check_model("glitch_idle");
    send_frame(8'h4B, 1, 1, 4, 1'b0);
    model_frame(8'h4B, 1, 1);
    check_model("glitch_mid");
    do_pop(); do_pop();

    // Overflow: nine codes into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      code = 8'h10 + 8'(i);
      send_frame(code, 1, 1, -1, 1'b0);
      model_frame(code, 1, 1);
    end
    check_model("overflow");
    check("overflow head", 32'(oData), 32'h10);
    do_pop();
    send_frame(8'h19, 1, 1, -1, 1'b0);
    model_frame(8'h19, 1, 1);
    check_model("refill");
    // Pop and push landing together while full.
    send_frame(8'h1A, 1, 1, -1, 1'b1);
    void'(m_q.pop_front());
    model_frame(8'h1A, 1, 1);
    check_model("full_pushpop");
    for (int i = 0; i < DEPTH; i++) begin
      check_model($sformatf("drain%0d", i));
      do_pop();
    end
    check_model("drained");

    // Random frames against the model.
    for (int n = 0; n < 40; n++) begin
      pre = 8'($urandom_range(0, 9));
      if (pre == 8'd0)      code = 8'hE0;
      else if (pre == 8'd1) code = 8'hF0;
      else                  code = 8'($urandom_range(0, 255));
      begin
        bit pok, sok;
        pok = ($urandom_range(0, 9) != 0);
        sok = ($urandom_range(0, 14) != 0);
        send_frame(code, pok, sok, -1, 1'b0);
        model_frame(code, pok, sok);
      end
      check_model($sformatf("rnd%0d", n));
      if ($urandom_range(0, 9) < 4) do_pop();
    end

    // Reset in the middle of a frame with a code already queued.
    send_frame(8'h41, 1, 1, -1, 1'b0);
    model_frame(8'h41, 1, 1);
    for (int i = 0; i < 4; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1, 1'b0, 1'b0);
    @(negedge Clock) Reset = 1'b1;
    #1;
    check_all_zero("midreset");
    PS2_CLK = 1'b1; PS2_DATA = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    repeat (5) @(negedge Clock);
    send_frame(8'h42, 1, 1, -1, 1'b0);
    model_frame(8'h42, 1, 1);
    check_model("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
